// File: rtl/seg_scan.sv
// seg_scan: multiplexed seven-segment display controller.
// Drives DIGITS hex digits in time-multiplexed order. SCAN_DIV clocks make one digit slot.
// The input value and decimal points are latched into a shadow register once per frame,
// so a displayed frame never mixes two values.
// Every digit change is preceded by a one-cycle blank to suppress ghosting.
// Optional macro SEG_SCAN_ZERO_BLANK_EN turns on leading-zero suppression.
module seg_scan #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_tick
);

  localparam int unsigned       PrescW    = $clog2(SCAN_DIV);
  localparam int unsigned       IdxW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(DIGITS - 1);
  localparam logic [7:0]        SegOff    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DigOff    = SEG_ACTIVE_LOW ? '1 : '0;

  // Active-high segment pattern, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [PrescW-1:0]   presc_q, presc_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                run_q, run_d;      // an enabled edge has been seen since reset/en rise
  logic                blank_q, blank_d;
  logic                tick_q, tick_d;
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                term;
  logic                frame_start;

  logic [3:0]          nib [DIGITS];
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_sup;
  logic [7:0]          seg_hi;
  logic [DIGITS-1:0]   dig_hi;

  assign term = (presc_q == PrescLast);

  // Prescaler, digit index, blank flag and frame-start shadow load.
  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    run_d        = run_q;
    blank_d      = 1'b0;
    frame_start  = 1'b0;
    if (!en) begin
      presc_d = '0;
      idx_d   = '0;
      run_d   = 1'b0;
    end else begin
      run_d   = 1'b1;
      presc_d = term ? '0 : presc_q + 1'b1;
      if (!run_q) begin
        // First enabled edge: start a frame at digit 0 immediately.
        idx_d       = '0;
        frame_start = 1'b1;
      end else if (term) begin
        blank_d = 1'b1;
        if (idx_q == IdxLast) begin
          idx_d       = '0;
          frame_start = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
    tick_d       = frame_start;
    shadow_val_d = frame_start ? value : shadow_val_q;
    shadow_dp_d  = frame_start ? dp : shadow_dp_q;
  end

  // Split the next shadow value into per-digit nibbles.
  always_comb begin
    for (int i = 0; i < int'(DIGITS); i++) begin
      nib[i] = shadow_val_d[4*i +: 4];
    end
  end

`ifdef SEG_SCAN_ZERO_BLANK_EN
  logic [DIGITS-1:0] zsup;
  logic              seen_nz;

  // Mark digits above the most significant non-zero nibble; digit 0 is never suppressed.
  always_comb begin
    zsup    = '0;
    seen_nz = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (nib[i] != 4'h0) seen_nz = 1'b1;
      zsup[i] = ~seen_nz;
    end
  end

  assign cur_sup = zsup[idx_d];
`else
  assign cur_sup = 1'b0;
`endif

  // Output pattern for the next cycle, derived from next-state so outputs track the state.
  always_comb begin
    cur_nib = nib[idx_d];
    cur_dp  = shadow_dp_d[idx_d];
    seg_hi  = {cur_dp, hex_to_seg(cur_nib)};
    if (cur_sup) seg_hi[6:0] = 7'h00;
    dig_hi = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig_hi[i] = (idx_d == IdxW'(i));
    end
    if (!en || blank_d) begin
      seg_d = SegOff;
      dig_d = DigOff;
    end else begin
      seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      dig_d = SEG_ACTIVE_LOW ? ~dig_hi : dig_hi;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      run_q        <= 1'b0;
      blank_q      <= 1'b0;
      tick_q       <= 1'b0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      seg_q        <= SegOff;
      dig_q        <= DigOff;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      run_q        <= run_d;
      blank_q      <= blank_d;
      tick_q       <= tick_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
    end
  end

  assign seg        = seg_q;
  assign dig        = dig_q;
  assign frame_tick = tick_q;

  // blank_q mirrors the blank decision for debug visibility; outputs use blank_d.
  logic unused_blank;
  assign unused_blank = blank_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: u0 is active-low (board polarity), u1 is active-high.
// Both use DIGITS=4, SCAN_DIV=4 so a frame is 16 cycles.
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [15:0] value1;
  logic [3:0]  dp1;
  logic [7:0]  seg0, seg1;
  logic [3:0]  dig0, dig1;
  logic        ft0, ft1;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_a [4];
  logic [7:0] exp_b [4];

  seg_scan #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) u0 (
    .clk(clk), .rst(rst), .en(en), .value(value), .dp(dp),
    .seg(seg0), .dig(dig0), .frame_tick(ft0)
  );

  seg_scan #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(en), .value(value1), .dp(dp1),
    .seg(seg1), .dig(dig1), .frame_tick(ft1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Active-high pattern expected from u1 (value 0, dp on digit 1).
  function automatic logic [7:0] u1_seg(input int idx);
`ifdef SEG_SCAN_ZERO_BLANK_EN
    if (idx == 0) return 8'h3F;
    if (idx == 1) return 8'h80;
    return 8'h00;
`else
    return (idx == 1) ? 8'hBF : 8'h3F;
`endif
  endfunction

  initial begin
    int idx;
    logic [7:0] es;
    logic [3:0] ed;
    logic       eft;

    exp_a = '{8'h99, 8'hB0, 8'hA4, 8'hF9};  // 4,3,2,1 active-low
    exp_b = '{8'hA1, 8'hC6, 8'h83, 8'h88};  // d,C,b,A active-low

    rst    = 1'b0;
    en     = 1'b1;
    value  = 16'h1234;
    dp     = 4'h0;
    value1 = 16'h0000;
    dp1    = 4'b0010;

    // Held in reset: everything off, no tick.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_seg", 32'(seg0), 32'h FF);
      chk("rst_dig", 32'(dig0), 32'h F);
      chk("rst_ft", 32'(ft0), 32'h0);
      chk("rst_seg_hi", 32'(seg1), 32'h00);
      chk("rst_dig_hi", 32'(dig1), 32'h0);
    end

    rst = 1'b1;

    // Three frames; value switches mid-frame 1 and must first appear in frame 2.
    for (int e = 1; e <= 47; e++) begin
      step();
      eft = (e == 1) || (e % 16 == 0);
      if (e % 4 == 0) begin
        chk("scan_blank_seg", 32'(seg0), 32'hFF);
        chk("scan_blank_dig", 32'(dig0), 32'hF);
        chk("pol_blank_seg", 32'(seg1), 32'h00);
        chk("pol_blank_dig", 32'(dig1), 32'h0);
      end else begin
        idx = (e / 4) % 4;
        es  = (e >= 32) ? exp_b[idx] : exp_a[idx];
        ed  = ~(4'b0001 << idx);
        chk("scan_seg", 32'(seg0), 32'(es));
        chk("scan_dig", 32'(dig0), 32'(ed));
        chk("pol_seg", 32'(seg1), 32'(u1_seg(idx)));
        chk("pol_dig", 32'(dig1), 32'(4'b0001 << idx));
      end
      chk("frame_tick", 32'(ft0), 32'(eft));
      if (e == 18) value = 16'hABCD;
    end

    // Advance to edge 57 (digit 2 lit), then drop en.
    for (int i = 0; i < 10; i++) step();
    chk("pre_drop_dig", 32'(dig0), 32'hB);
    chk("pre_drop_seg", 32'(seg0), 32'h83);
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("dis_seg", 32'(seg0), 32'hFF);
      chk("dis_dig", 32'(dig0), 32'hF);
      chk("dis_ft", 32'(ft0), 32'h0);
    end

    // Re-enable: restart at digit 0 with a tick and fresh shadow.
    en = 1'b1;
    step();
    chk("reen_ft", 32'(ft0), 32'h1);
    chk("reen_dig", 32'(dig0), 32'hE);
    chk("reen_seg", 32'(seg0), 32'hA1);
    step();
    chk("reen_ft2", 32'(ft0), 32'h0);
    chk("reen_dig2", 32'(dig0), 32'hE);
    step();
    step();
    chk("reen_blank", 32'(seg0), 32'hFF);
    step();
    chk("reen_d1", 32'(dig0), 32'hD);

    // Asynchronous reset mid-slot.
    #2;
    rst = 1'b0;
    #1;
    chk("arst_seg", 32'(seg0), 32'hFF);
    chk("arst_dig", 32'(dig0), 32'hF);
    chk("arst_ft", 32'(ft0), 32'h0);
    chk("arst_seg_hi", 32'(seg1), 32'h00);

`ifdef SEG_SCAN_ZERO_BLANK_EN
    value = 16'h0050;
    dp    = 4'h0;
    #2;
    rst = 1'b1;
    step();
    chk("zb_d0_seg", 32'(seg0), 32'hC0);
    chk("zb_d0_dig", 32'(dig0), 32'hE);
    for (int i = 0; i < 4; i++) step();
    chk("zb_d1_seg", 32'(seg0), 32'h92);
    chk("zb_d1_dig", 32'(dig0), 32'hD);
    for (int i = 0; i < 4; i++) step();
    chk("zb_d2_seg", 32'(seg0), 32'hFF);
    chk("zb_d2_dig", 32'(dig0), 32'hB);
    for (int i = 0; i < 4; i++) step();
    chk("zb_d3_seg", 32'(seg0), 32'hFF);
    chk("zb_d3_dig", 32'(dig0), 32'h7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Parametrised multiplexed seven-segment display controller for the board top level.
- Generalises the single-digit counter/segment-decoder path to DIGITS time-multiplexed hex digits, with a refresh prescaler, per-digit decimal points and selectable output polarity.
- Input value is latched once per frame, so the display never shows a mix of two values (no tearing).
- A one-cycle ghost-suppression blank is inserted at every digit change.

Parameters:
- DIGITS, 4: number of digits; legal range 1..8.
- SCAN_DIV, 50000: clk cycles per digit slot; legal range 2..2^20.
- SEG_ACTIVE_LOW, 1: 1 = seg and dig driven active-low (board wiring); 0 = active-high.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- en, in, 1: display enable.
- value, in, 4*DIGITS: hex digits; digit i = value[4i+3:4i], digit 0 rightmost.
- dp, in, DIGITS: decimal point per digit; 1 = lit.
- seg, out, 8: seg[6:0] = segments g..a (bit0 = a); seg[7] = dp.
- dig, out, DIGITS: digit select, one-hot when active.
- frame_tick, out, 1: one-cycle pulse on each frame start.

Behaviour:
- Reset (rst=0, asynchronous):
  - prescaler=0, index=0, shadow value/dp=0, frame_tick=0, blank flag=0.
  - seg = all segments off; dig = all digits off (polarity per SEG_ACTIVE_LOW).
- Prescaler counts 0..SCAN_DIV-1 while en=1. At terminal count (SCAN_DIV-1), next edge:
  - prescaler returns to 0;
  - index advances (DIGITS-1 wraps to 0);
  - blank flag is set for exactly one cycle.
- Frame start: the edge on which index wraps to 0.
  - value and dp are copied into shadow registers.
  - frame_tick=1 for that single cycle.
- Frame-start exception: the first frame after reset or after en rises starts at index 0. Shadow is loaded on that first enabled edge, with frame_tick=1.
- Output register (all outputs registered, updated every edge):
  - blank flag=1: dig all off, seg all off.
  - otherwise: dig = onehot(index), seg = decode(shadow nibble[index]) with seg[7] = shadow dp[index].
- Latency: digit change is visible 2 edges after the terminal-count cycle (one blank cycle, then the new digit).
- Slot timing: each digit is lit SCAN_DIV-1 cycles and blanked 1 cycle per slot; frame period = DIGITS*SCAN_DIV cycles.
- Decode, active-high encoding:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- SEG_ACTIVE_LOW=1: seg and dig are the bitwise inverse of the active-high encoding.
- en=0:
  - prescaler and index reset to 0; shadow holds;
  - outputs all off from the next edge; frame_tick=0.
- en re-asserted: behaves as the first frame after reset (index 0, shadow reload, frame_tick pulse).
- value changes mid-frame: no effect until the next frame start.
- Reset mid-frame: all state cleared immediately, independent of clk.
- DIGITS=1: index fixed at 0. Every slot boundary is a frame start, so frame_tick pulses every SCAN_DIV cycles and the blank cycle still occurs.

Optional Feature:
- Macro: SEG_SCAN_ZERO_BLANK_EN.
- Defined: leading-zero suppression. Digits above the most significant non-zero shadow nibble are blanked.
  - For a blanked digit: dig stays asserted for its slot, seg[6:0] off, dp still honoured.
  - Digit 0 always displays, so a shadow value of 0 shows "0".
  - Decision is based on the shadow, so it changes only at frame start.
- Undefined: all digits always decoded; no suppression logic synthesised.

Test Plan:
- Reset/idle: rst=0 with en=1, value=16'h1234 (DIGITS=4, SCAN_DIV=4, SEG_ACTIVE_LOW=1) -> seg=8'hFF, dig=4'hF, frame_tick=0 throughout reset.
- Scan order: release rst, en=1, value=16'h1234, dp=0 -> frame_tick pulses once on the first edge. Lit digits are then:
  - dig=4'hE, seg=8'h99;
  - dig=4'hD, seg=8'hB0;
  - dig=4'hB, seg=8'hA4;
  - dig=4'h7, seg=8'hF9.
  - Each digit lit 3 cycles, with 1 blank cycle (seg=FF, dig=F) between digits.
  - frame_tick repeats every 16 cycles.
- Tear-free latch: change value to 16'hABCD mid-frame -> remaining digits still show 3/2/1. From the next frame_tick: digit 0 seg=8'hA1 (d), digit 3 seg=8'h88 (A).
- Decimal point/polarity: SEG_ACTIVE_LOW=0, value=0, dp=4'b0010 -> digit 1 seg=8'hBF, other digits seg=8'h3F, dig one-hot active-high.
- Enable/reset mid-operation:
  - drop en during digit 2 -> outputs off on the next edge;
  - re-raise en -> restarts at digit 0 with frame_tick;
  - assert rst mid-slot -> outputs off without waiting for a clk edge.
- With SEG_SCAN_ZERO_BLANK_EN: value=16'h0050 -> digits 3 and 2 show seg=8'hFF with dig asserted; digit 1 shows 8'h92 (5); digit 0 shows 8'hC0 (0).
